// File: rtl/atan_poly_quad.sv
// Four-stage odd-cubic arctangent with octant correction; output is a binary angle (pi = 2^(ANG_W-1)).
// Optional build macro ATAN_ROUND_EN: round-half-up on each >>> 7 instead of floor.
module atan_poly_quad #(
    parameter int ANG_W = 16,
    parameter int C1    = 10143,
    parameter int C3    = 2002
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    val_i,
    input  logic signed [7:0]       ratio_i,
    input  logic [2:0]              case_flag_i,
    output logic signed [ANG_W-1:0] angle_o,
    output logic                    val_o
);

    localparam logic signed [23:0] C1_S = 24'(C1);
    localparam logic signed [31:0] C3_S = 32'(C3);

`ifdef ATAN_ROUND_EN
    localparam logic signed [23:0] RND24 = 24'sd64;
    localparam logic signed [31:0] RND32 = 32'sd64;
`else
    localparam logic signed [23:0] RND24 = 24'sd0;
    localparam logic signed [31:0] RND32 = 32'sd0;
`endif

    localparam logic [ANG_W-1:0] Q_P   = {2'b01, {(ANG_W-2){1'b0}}};
    localparam logic [ANG_W-1:0] Q_N   = {2'b11, {(ANG_W-2){1'b0}}};
    localparam logic [ANG_W-1:0] TWO_Q = {1'b1, {(ANG_W-1){1'b0}}};

    logic [3:0]              r_vld;

    logic signed [7:0]       r_s1_r;
    logic [2:0]              r_s1_cf;
    logic [14:0]             r_s1_x2;
    logic signed [23:0]      r_s1_lin;

    logic signed [15:0]      r_s2_x3;
    logic [2:0]              r_s2_cf;
    logic signed [23:0]      r_s2_lin;

    logic signed [ANG_W-1:0] r_s3_poly;
    logic [2:0]              r_s3_cf;

    logic signed [ANG_W-1:0] r_angle;

    // Stage 1: |r|^2 on the magnitude keeps x2 unsigned; 128^2 = 2^14 still fits 15 bits.
    logic [7:0]         w_mag;
    logic [14:0]        w_x2;
    logic signed [23:0] w_r_ext;
    logic signed [23:0] w_lin;

    assign w_mag   = ratio_i[7] ? (~ratio_i + 8'd1) : ratio_i;
    assign w_x2    = {7'd0, w_mag} * {7'd0, w_mag};
    assign w_r_ext = $signed({{16{ratio_i[7]}}, ratio_i});
    assign w_lin   = C1_S * w_r_ext;

    logic signed [23:0] w_s1_r_ext;
    logic signed [23:0] w_x2r;

    assign w_s1_r_ext = $signed({{16{r_s1_r[7]}}, r_s1_r});
    assign w_x2r      = $signed({9'd0, r_s1_x2}) * w_s1_r_ext + RND24;

    logic signed [31:0]      w_x3_ext;
    logic signed [31:0]      w_c3x3;
    logic signed [23:0]      w_cub;
    logic signed [23:0]      w_diff;
    logic signed [ANG_W-1:0] w_poly;

    assign w_x3_ext = $signed({{16{r_s2_x3[15]}}, r_s2_x3});
    assign w_c3x3   = C3_S * w_x3_ext + RND32;
    assign w_cub    = 24'(w_c3x3 >>> 7);
    assign w_diff   = r_s2_lin - w_cub + RND24;
    assign w_poly   = ANG_W'(w_diff >>> 7);

    logic [ANG_W-1:0] w_angle;

    always_comb begin
        w_angle = '0;
        unique case (r_s3_cf)
            3'd0: w_angle = '0;
            3'd1: w_angle = r_s3_poly;
            3'd2: w_angle = TWO_Q + r_s3_poly;
            3'd3: w_angle = '0 - r_s3_poly;
            3'd4: w_angle = Q_N - r_s3_poly;
            3'd5: w_angle = Q_P - r_s3_poly;
            3'd6: w_angle = Q_N + r_s3_poly;
            3'd7: w_angle = Q_P + r_s3_poly;
            default: w_angle = '0;
        endcase
    end

    // Each stage's data only moves when its own valid bit is set, so results hold between samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_s1_r    <= '0;
            r_s1_cf   <= '0;
            r_s1_x2   <= '0;
            r_s1_lin  <= '0;
            r_s2_x3   <= '0;
            r_s2_cf   <= '0;
            r_s2_lin  <= '0;
            r_s3_poly <= '0;
            r_s3_cf   <= '0;
            r_angle   <= '0;
        end else begin
            r_vld <= {r_vld[2:0], val_i};
            if (val_i) begin
                r_s1_r   <= ratio_i;
                r_s1_cf  <= case_flag_i;
                r_s1_x2  <= w_x2;
                r_s1_lin <= w_lin;
            end
            if (r_vld[0]) begin
                r_s2_x3  <= 16'(w_x2r >>> 7);
                r_s2_cf  <= r_s1_cf;
                r_s2_lin <= r_s1_lin;
            end
            if (r_vld[1]) begin
                r_s3_poly <= w_poly;
                r_s3_cf   <= r_s2_cf;
            end
            if (r_vld[2]) begin
                r_angle <= $signed(w_angle);
            end
        end
    end

    assign angle_o = r_angle;
    assign val_o   = r_vld[3];

endmodule

// File: tb/tb_atan_poly_quad.sv
// Directed bench for atan_poly_quad: latency, case table, wrap, pipelining, hold and reset flush.
module tb_atan_poly_quad;

    localparam int ANG_W = 16;

    logic              clk;
    logic              rst_n;
    logic              val_i;
    logic signed [7:0] ratio_i;
    logic [2:0]        case_flag_i;
    logic signed [15:0] angle_o;
    logic              val_o;

    int n_checks = 0;
    int n_fail   = 0;

    atan_poly_quad #(.ANG_W(ANG_W), .C1(10143), .C3(2002)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .val_i       (val_i),
        .ratio_i     (ratio_i),
        .case_flag_i (case_flag_i),
        .angle_o     (angle_o),
        .val_o       (val_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%04h) exp=%0d (0x%04h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Golden integer model of the whole datapath.
    function automatic logic [15:0] model(input int r, input int cf);
        int rnd;
        int x2, lin, x3, cub, poly, ang;
`ifdef ATAN_ROUND_EN
        rnd = 64;
`else
        rnd = 0;
`endif
        x2   = r * r;
        lin  = 10143 * r;
        x3   = (x2 * r + rnd) >>> 7;
        cub  = (2002 * x3 + rnd) >>> 7;
        poly = (lin - cub + rnd) >>> 7;
        case (cf)
            0: ang = 0;
            1: ang = poly;
            2: ang = 32768 + poly;
            3: ang = -poly;
            4: ang = -16384 - poly;
            5: ang = 16384 - poly;
            6: ang = -16384 + poly;
            default: ang = 16384 + poly;
        endcase
        return 16'(ang);
    endfunction

    // One isolated sample: val_o must stay low for 3 cycles and pulse on the 4th.
    task automatic one_sample(input string tag, input logic signed [7:0] r, input logic [2:0] cf,
                              input logic [15:0] exp);
        @(negedge clk);
        ratio_i     = r;
        case_flag_i = cf;
        val_i       = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            val_i = 1'b0;
            if (k < 4) begin
                check($sformatf("%s_vlo%0d", tag, k), {15'd0, val_o}, 16'd0);
            end else begin
                check($sformatf("%s_vhi", tag), {15'd0, val_o}, 16'd1);
                check($sformatf("%s_ang", tag), angle_o, exp);
            end
        end
        @(negedge clk);
        check($sformatf("%s_vend", tag), {15'd0, val_o}, 16'd0);
    endtask

    logic [15:0] exp_sw [8];
    logic [15:0] exp_m64_cf2;

    initial begin
        exp_sw = '{16'd0, 16'd8108, 16'd40876, 16'd57428, 16'd41044, 16'd8276, 16'd57260, 16'd24492};
`ifdef ATAN_ROUND_EN
        exp_m64_cf2 = 16'd27947;
`else
        exp_m64_cf2 = 16'd27946;
`endif
        rst_n       = 1'b0;
        val_i       = 1'b0;
        ratio_i     = '0;
        case_flag_i = '0;
        repeat (3) @(negedge clk);
        check("rst_val", {15'd0, val_o}, 16'd0);
        check("rst_ang", angle_o, 16'd0);
        rst_n = 1'b1;

        one_sample("zero_cf1", 8'sd0, 3'd1, 16'd0);
        one_sample("p127_cf1", 8'sd127, 3'd1, 16'd8108);
        one_sample("p127_cf3", 8'sd127, 3'd3, 16'hE054);
        one_sample("p127_cf5", 8'sd127, 3'd5, 16'd8276);
        one_sample("m64_cf2", -8'sd64, 3'd2, exp_m64_cf2);
        one_sample("m64_cf0", -8'sd64, 3'd0, 16'd0);
        one_sample("zero_cf6", 8'sd0, 3'd6, 16'hC000);
        one_sample("zero_cf2_wrap", 8'sd0, 3'd2, 16'h8000);
        one_sample("m128_cf1", -8'sd128, 3'd1, model(-128, 1));
        one_sample("m128_cf4", -8'sd128, 3'd4, model(-128, 4));

        // Eight back-to-back samples sweeping cf, then a gap during which angle_o must hold.
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j < 4) begin
                check($sformatf("sw_pre%0d", j), {15'd0, val_o}, 16'd0);
            end else if (j < 12) begin
                check($sformatf("sw_v%0d", j - 4), {15'd0, val_o}, 16'd1);
                check($sformatf("sw_ang%0d", j - 4), angle_o, exp_sw[j - 4]);
            end else begin
                check($sformatf("sw_gap_v%0d", j), {15'd0, val_o}, 16'd0);
                check($sformatf("sw_gap_hold%0d", j), angle_o, exp_sw[7]);
            end
            if (j < 8) begin
                ratio_i     = 8'sd127;
                case_flag_i = 3'(j);
                val_i       = 1'b1;
            end else begin
                val_i = 1'b0;
            end
        end

        // Three samples in flight, then a one-cycle reset must flush them.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            ratio_i     = 8'sd127;
            case_flag_i = 3'd7;
            val_i       = 1'b1;
        end
        @(negedge clk);
        val_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("flush_val", {15'd0, val_o}, 16'd0);
        check("flush_ang", angle_o, 16'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("flush_stale%0d", j), {15'd0, val_o}, 16'd0);
        end
        check("flush_ang_hold", angle_o, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
